// File: rtl/scr1_tcm_sp_arb.sv
// Single-port TCM shared by the core imem and dmem ports. Per-cycle arbitration
// with a starvation guard for imem, range/alignment error responses and a read pipeline.

package scr1_tcm_sp_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10,
    SCR1_MEM_RESP_ERROR  = 2'b11
  } type_scr1_mem_resp_e;

  typedef struct packed {
    logic                 valid;
    logic                 err;
    type_scr1_mem_cmd_e   cmd;
    type_scr1_mem_width_e width;
    logic [1:0]           offset;
    logic [31:0]          data;
  } type_tcm_stage_s;

endpackage

module scr1_tcm_sp_arb
  import scr1_tcm_sp_pkg::*;
#(
  parameter logic [31:0] TCM_BASE     = 32'h0000_0000,
  parameter logic [31:0] TCM_SIZE     = 32'h0001_0000,
  parameter int          RD_LATENCY   = 1,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 imem_req,
  output logic                 imem_req_ack,
  input  type_scr1_mem_cmd_e   imem_cmd,
  input  logic [31:0]          imem_addr,
  output logic [31:0]          imem_rdata,
  output type_scr1_mem_resp_e  imem_resp,
  input  logic                 dmem_req,
  output logic                 dmem_req_ack,
  input  type_scr1_mem_cmd_e   dmem_cmd,
  input  type_scr1_mem_width_e dmem_width,
  input  logic [31:0]          dmem_addr,
  input  logic [31:0]          dmem_wdata,
  output logic [31:0]          dmem_rdata,
  output type_scr1_mem_resp_e  dmem_resp
);

  localparam int         AW         = $clog2(TCM_SIZE);
  localparam int         DEPTH      = 1 << (AW - 2);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  function automatic logic in_range(input logic [31:0] addr);
    return (addr >= TCM_BASE) && ((addr - TCM_BASE) < TCM_SIZE);
  endfunction

  function automatic logic dmem_misaligned(input type_scr1_mem_width_e width,
                                           input logic [1:0] ofs);
    logic mis;
    case (width)
      SCR1_MEM_WIDTH_BYTE:  mis = 1'b0;
      SCR1_MEM_WIDTH_HWORD: mis = ofs[0];
      SCR1_MEM_WIDTH_WORD:  mis = (ofs != 2'b00);
      default:              mis = 1'b1;
    endcase
    return mis;
  endfunction

  function automatic logic [3:0] byte_en(input type_scr1_mem_width_e width,
                                         input logic [1:0] ofs);
    logic [3:0] be;
    case (width)
      SCR1_MEM_WIDTH_BYTE:  be = 4'b0001 << ofs;
      SCR1_MEM_WIDTH_HWORD: be = 4'b0011 << {ofs[1], 1'b0};
      SCR1_MEM_WIDTH_WORD:  be = 4'b1111;
      default:              be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_rep(input type_scr1_mem_width_e width,
                                            input logic [31:0] data);
    logic [31:0] rep;
    case (width)
      SCR1_MEM_WIDTH_BYTE:  rep = {4{data[7:0]}};
      SCR1_MEM_WIDTH_HWORD: rep = {2{data[15:0]}};
      default:              rep = data;
    endcase
    return rep;
  endfunction

  function automatic logic [31:0] format_rdata(input type_tcm_stage_s st);
    logic [31:0] shifted;
    logic [31:0] res;
    shifted = st.data >> {st.offset, 3'b000};
    if (!st.valid || st.err || (st.cmd == SCR1_MEM_CMD_WR)) begin
      res = 32'h0000_0000;
    end else begin
      case (st.width)
        SCR1_MEM_WIDTH_BYTE:  res = {24'h00_0000, shifted[7:0]};
        SCR1_MEM_WIDTH_HWORD: res = {16'h0000, shifted[15:0]};
        default:              res = shifted;
      endcase
    end
    return res;
  endfunction

  logic [3:0]      starve_cnt;
  logic            imem_grant;
  logic            dmem_grant;
  logic            imem_err;
  logic            dmem_err;
  logic [AW-3:0]   acc_idx;
  logic            acc_we;
  logic [3:0]      acc_be;
  logic [31:0]     acc_wdata;
  logic [31:0]     acc_rdata;
  logic [31:0]     mem [DEPTH];
  type_tcm_stage_s imem_new;
  type_tcm_stage_s dmem_new;
  type_tcm_stage_s imem_st [RD_LATENCY];
  type_tcm_stage_s dmem_st [RD_LATENCY];
  type_tcm_stage_s imem_last;
  type_tcm_stage_s dmem_last;

  // dmem has priority unless imem has already lost STARVE_LIMIT times in a row
  always_comb begin
    imem_grant = 1'b0;
    dmem_grant = 1'b0;
    if (imem_req && (!dmem_req || (starve_cnt == STARVE_MAX))) begin
      imem_grant = 1'b1;
    end else if (dmem_req) begin
      dmem_grant = 1'b1;
    end else begin
      dmem_grant = 1'b0;
    end
  end

  assign imem_req_ack = imem_grant;
  assign dmem_req_ack = dmem_grant;

  // Request checks applied at acceptance
  always_comb begin
    imem_err = !in_range(imem_addr) || (imem_addr[1:0] != 2'b00) ||
               (imem_cmd == SCR1_MEM_CMD_WR);
    dmem_err = !in_range(dmem_addr) || dmem_misaligned(dmem_width, dmem_addr[1:0]);
  end

  // TCM_BASE is aligned to TCM_SIZE, so the low address bits are already the array offset
  always_comb begin
    acc_idx   = imem_grant ? imem_addr[AW-1:2] : dmem_addr[AW-1:2];
    acc_we    = dmem_grant && (dmem_cmd == SCR1_MEM_CMD_WR) && !dmem_err;
    acc_be    = byte_en(dmem_width, dmem_addr[1:0]);
    acc_wdata = wdata_rep(dmem_width, dmem_wdata);
  end

  assign acc_rdata = mem[acc_idx];

  // Entries pushed into the head of each response pipeline
  always_comb begin
    imem_new        = '0;
    imem_new.valid  = imem_grant;
    imem_new.err    = imem_err;
    imem_new.cmd    = imem_cmd;
    imem_new.width  = SCR1_MEM_WIDTH_WORD;
    imem_new.offset = 2'b00;
    imem_new.data   = imem_err ? 32'h0000_0000 : acc_rdata;
    dmem_new        = '0;
    dmem_new.valid  = dmem_grant;
    dmem_new.err    = dmem_err;
    dmem_new.cmd    = dmem_cmd;
    dmem_new.width  = dmem_width;
    dmem_new.offset = dmem_addr[1:0];
    dmem_new.data   = dmem_err ? 32'h0000_0000 : acc_rdata;
  end

  // Consecutive lost imem arbitrations, saturating at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (imem_req && !imem_grant) begin
      starve_cnt <= (starve_cnt == STARVE_MAX) ? STARVE_MAX : starve_cnt + 4'd1;
    end else begin
      starve_cnt <= 4'd0;
    end
  end

  // Response pipelines; a reset drops everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        imem_st[i] <= '0;
        dmem_st[i] <= '0;
      end
    end else begin
      imem_st[0] <= imem_new;
      dmem_st[0] <= dmem_new;
      for (int i = 1; i < RD_LATENCY; i++) begin
        imem_st[i] <= imem_st[i-1];
        dmem_st[i] <= dmem_st[i-1];
      end
    end
  end

  // Array write port; contents survive reset
  always_ff @(posedge clk) begin
    if (acc_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) begin
          mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  assign imem_last = imem_st[RD_LATENCY-1];
  assign dmem_last = dmem_st[RD_LATENCY-1];

  // Response decode from the last pipeline stage
  always_comb begin
    imem_resp = SCR1_MEM_RESP_NOTRDY;
    dmem_resp = SCR1_MEM_RESP_NOTRDY;
    if (imem_last.valid) begin
      imem_resp = imem_last.err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
    end else begin
      imem_resp = SCR1_MEM_RESP_NOTRDY;
    end
    if (dmem_last.valid) begin
      dmem_resp = dmem_last.err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
    end else begin
      dmem_resp = SCR1_MEM_RESP_NOTRDY;
    end
    imem_rdata = format_rdata(imem_last);
    dmem_rdata = format_rdata(dmem_last);
  end

endmodule

// File: tb/tb_scr1_tcm_sp_arb.sv
// Bench for scr1_tcm_sp_arb: three instances (RD_LATENCY 1..3) share one stimulus stream
// and are checked every cycle against a transaction-level model of the TCM.
`timescale 1ns/1ps

module tb_scr1_tcm_sp_arb;
  import scr1_tcm_sp_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] SIZE  = 32'h0001_0000;
  localparam int          NI    = 3;
  localparam int          LIMIT = 4;
  localparam logic [1:0]  R_NR  = 2'b00;
  localparam logic [1:0]  R_OK  = 2'b01;
  localparam logic [1:0]  R_ER  = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 imem_req, dmem_req;
  type_scr1_mem_cmd_e   imem_cmd, dmem_cmd;
  type_scr1_mem_width_e dmem_width;
  logic [31:0]          imem_addr, dmem_addr, dmem_wdata;
  logic                 i_ack [NI];
  logic                 d_ack [NI];
  logic [31:0]          i_rdata [NI];
  logic [31:0]          d_rdata [NI];
  logic [1:0]           i_resp [NI];
  logic [1:0]           d_resp [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    scr1_tcm_sp_arb #(
      .TCM_BASE(BASE), .TCM_SIZE(SIZE), .RD_LATENCY(g + 1), .STARVE_LIMIT(LIMIT)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_req_ack(i_ack[g]), .imem_cmd(imem_cmd),
      .imem_addr(imem_addr), .imem_rdata(i_rdata[g]), .imem_resp(i_resp[g]),
      .dmem_req(dmem_req), .dmem_req_ack(d_ack[g]), .dmem_cmd(dmem_cmd),
      .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(d_rdata[g]), .dmem_resp(d_resp[g])
    );
  end

  typedef struct {
    type_scr1_mem_cmd_e   cmd;
    type_scr1_mem_width_e width;
    logic [31:0]          addr;
    logic [31:0]          wdata;
  } req_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  req_t        iq[$];
  req_t        dq[$];
  exp_t        ei[int];
  exp_t        ed[int];
  logic [31:0] mm[int];
  logic [31:0] cap_i[$];
  logic [31:0] cap_d[$];
  int          cyc = 0, chk_cnt = 0, pass_cnt = 0;
  int          wait_cnt = 0, dut_wait = 0, max_wait = 0;
  bit          rec_hist = 1'b0;
  int          hist_n = 0;
  logic [9:0]  hist;
  logic [9:0]  pat;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic in_rng(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE}) && ({1'b0, a} < ({1'b0, BASE} + {1'b0, SIZE}));
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    int k;
    k = int'(a >> 2);
    return mm.exists(k) ? mm[k] : 32'h0000_0000;
  endfunction

  function automatic exp_t imem_model(input req_t r);
    exp_t e;
    if (!in_rng(r.addr) || (r.addr[1:0] != 2'b00) || (r.cmd == SCR1_MEM_CMD_WR))
      e = '{R_ER, 32'h0};
    else
      e = '{R_OK, rd_word(r.addr)};
    return e;
  endfunction

  task automatic dmem_model(input req_t r, output exp_t e);
    int          off;
    logic [31:0] w;
    off = int'(r.addr[1:0]);
    if (!in_rng(r.addr) ||
        (r.width == SCR1_MEM_WIDTH_HWORD && (off % 2) != 0) ||
        (r.width == SCR1_MEM_WIDTH_WORD && off != 0)) begin
      e = '{R_ER, 32'h0};
    end else if (r.cmd == SCR1_MEM_CMD_WR) begin
      w = rd_word(r.addr);
      if (r.width == SCR1_MEM_WIDTH_BYTE)       w[8*off +: 8]  = r.wdata[7:0];
      else if (r.width == SCR1_MEM_WIDTH_HWORD) w[8*off +: 16] = r.wdata[15:0];
      else                                      w = r.wdata;
      mm[int'(r.addr >> 2)] = w;
      e = '{R_OK, 32'h0};
    end else begin
      w = rd_word(r.addr) >> (8 * off);
      if (r.width == SCR1_MEM_WIDTH_BYTE)       w = w & 32'h0000_00FF;
      else if (r.width == SCR1_MEM_WIDTH_HWORD) w = w & 32'h0000_FFFF;
      else                                      w = w;
      e = '{R_OK, w};
    end
  endtask

  task automatic pd(input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                    input logic [31:0] a, input logic [31:0] d);
    req_t r;
    r = '{c, w, a, d};
    dq.push_back(r);
  endtask

  task automatic pi(input type_scr1_mem_cmd_e c, input logic [31:0] a);
    req_t r;
    r = '{c, SCR1_MEM_WIDTH_WORD, a, 32'h0};
    iq.push_back(r);
  endtask

  // One clock cycle: drive queue heads, check responses and acks, advance the model
  task automatic step();
    exp_t e;
    bit   gi, gd;
    int   k;
    @(negedge clk);
    imem_req = (iq.size() != 0);
    dmem_req = (dq.size() != 0);
    if (imem_req) begin
      imem_cmd = iq[0].cmd; imem_addr = iq[0].addr;
    end
    if (dmem_req) begin
      dmem_cmd = dq[0].cmd; dmem_width = dq[0].width;
      dmem_addr = dq[0].addr; dmem_wdata = dq[0].wdata;
    end
    #1;
    for (int g = 0; g < NI; g++) begin
      k = cyc - (g + 1);
      if (ei.exists(k)) begin
        check($sformatf("imem_resp_L%0d", g + 1), {30'h0, i_resp[g]}, {30'h0, ei[k].resp});
        check($sformatf("imem_rdata_L%0d", g + 1), i_rdata[g], ei[k].rdata);
      end else begin
        check($sformatf("imem_idle_L%0d", g + 1), {30'h0, i_resp[g]}, {30'h0, R_NR});
      end
      if (ed.exists(k)) begin
        check($sformatf("dmem_resp_L%0d", g + 1), {30'h0, d_resp[g]}, {30'h0, ed[k].resp});
        check($sformatf("dmem_rdata_L%0d", g + 1), d_rdata[g], ed[k].rdata);
      end else begin
        check($sformatf("dmem_idle_L%0d", g + 1), {30'h0, d_resp[g]}, {30'h0, R_NR});
      end
    end
    if (i_resp[0] != R_NR) cap_i.push_back(i_rdata[0]);
    if (d_resp[0] != R_NR) cap_d.push_back(d_rdata[0]);
    gi = imem_req && (!dmem_req || wait_cnt == LIMIT);
    gd = dmem_req && !gi;
    for (int g = 0; g < NI; g++) begin
      check($sformatf("imem_ack_L%0d", g + 1), {31'h0, i_ack[g]}, {31'h0, gi});
      check($sformatf("dmem_ack_L%0d", g + 1), {31'h0, d_ack[g]}, {31'h0, gd});
    end
    if (imem_req && !i_ack[0]) begin
      dut_wait++;
      if (dut_wait > max_wait) max_wait = dut_wait;
    end else begin
      dut_wait = 0;
    end
    if (rec_hist && hist_n < 10) begin
      hist[hist_n] = i_ack[0];
      hist_n++;
    end
    if (gi) begin
      ei[cyc] = imem_model(iq[0]);
      void'(iq.pop_front());
    end
    if (gd) begin
      dmem_model(dq[0], e);
      ed[cyc] = e;
      void'(dq.pop_front());
    end
    wait_cnt = (imem_req && !gi) ? ((wait_cnt < LIMIT) ? wait_cnt + 1 : LIMIT) : 0;
    @(posedge clk);
    cyc++;
  endtask

  task automatic run(input int drain);
    int n;
    n = 0;
    while ((iq.size() != 0 || dq.size() != 0) && n < 200) begin
      step();
      n++;
    end
    if (iq.size() != 0 || dq.size() != 0) begin
      chk_cnt++;
      $display("FAIL run_bound: requests still queued after %0d cycles", n);
      iq.delete();
      dq.delete();
    end
    repeat (drain) step();
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst_n = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    ei.delete();
    ed.delete();
    wait_cnt = 0;
    dut_wait = 0;
    repeat (hold) begin
      #1;
      for (int g = 0; g < NI; g++) begin
        check($sformatf("rst_imem_resp_L%0d", g + 1), {30'h0, i_resp[g]}, {30'h0, R_NR});
        check($sformatf("rst_dmem_resp_L%0d", g + 1), {30'h0, d_resp[g]}, {30'h0, R_NR});
        check($sformatf("rst_imem_rdata_L%0d", g + 1), i_rdata[g], 32'h0);
        check($sformatf("rst_dmem_rdata_L%0d", g + 1), d_rdata[g], 32'h0);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    imem_req = 1'b0; dmem_req = 1'b0;
    imem_cmd = SCR1_MEM_CMD_RD; dmem_cmd = SCR1_MEM_CMD_RD;
    dmem_width = SCR1_MEM_WIDTH_WORD;
    imem_addr = 32'h0; dmem_addr = 32'h0; dmem_wdata = 32'h0;
    do_reset(3);

    // Write then read back at three widths
    cap_d.delete();
    pd(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h100, 32'hDEAD_BEEF);
    pd(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, 32'h0);
    pd(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_BYTE, 32'h103, 32'h0);
    pd(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h102, 32'h0);
    run(5);
    check("p1_count", cap_d.size(), 32'd4);
    check("p1_word", qget(cap_d, 1), 32'hDEAD_BEEF);
    check("p1_byte", qget(cap_d, 2), 32'h0000_00DE);
    check("p1_hword", qget(cap_d, 3), 32'h0000_DEAD);

    // Back-to-back imem fetches
    pd(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0000_0013);
    pd(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h4, 32'h0010_0093);
    pd(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h8, 32'h0020_0113);
    run(5);
    cap_i.delete();
    pi(SCR1_MEM_CMD_RD, 32'h0);
    pi(SCR1_MEM_CMD_RD, 32'h4);
    pi(SCR1_MEM_CMD_RD, 32'h8);
    run(5);
    check("p2_fetch0", qget(cap_i, 0), 32'h0000_0013);
    check("p2_fetch1", qget(cap_i, 1), 32'h0010_0093);
    check("p2_fetch2", qget(cap_i, 2), 32'h0020_0113);

    // Both ports held: four dmem grants then one forced imem grant
    rec_hist = 1'b1;
    hist_n = 0;
    repeat (3) pi(SCR1_MEM_CMD_RD, 32'h0);
    repeat (10) pd(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, 32'h0);
    run(5);
    rec_hist = 1'b0;
    pat = 10'b10_0001_0000;
    for (int n = 0; n < 10; n++)
      check($sformatf("starve_ack%0d", n), {31'h0, hist[n]}, {31'h0, pat[n]});
    check("max_imem_wait", max_wait, 32'd4);

    // Error responses, then confirm the array was not disturbed
    pd(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, BASE + SIZE, 32'hFFFF_FFFF);
    pd(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h101, 32'h0);
    pd(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h102, 32'h0);
    pi(SCR1_MEM_CMD_RD, 32'h6);
    pi(SCR1_MEM_CMD_WR, 32'h0);
    run(5);
    cap_i.delete();
    cap_d.delete();
    pi(SCR1_MEM_CMD_RD, 32'h0);
    pd(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, 32'h0);
    pd(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
    run(5);
    check("p4_imem_word0", qget(cap_i, 0), 32'h0000_0013);
    check("p4_dmem_0x100", qget(cap_d, 0), 32'hDEAD_BEEF);
    check("p4_dmem_0x0", qget(cap_d, 1), 32'h0000_0013);

    // Byte write followed immediately by a word read of the same word
    pd(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h200, 32'h0);
    run(5);
    cap_d.delete();
    pd(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h201, 32'h0000_0055);
    pd(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h200, 32'h0);
    run(5);
    check("p5_rmw_word", qget(cap_d, 1), 32'h0000_5500);

    // Reset with reads in flight
    pd(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, 32'h0);
    pd(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, 32'h0);
    run(0);
    do_reset(3);
    cap_d.delete();
    repeat (6) step();
    check("p6_silent_after_reset", cap_d.size(), 32'd0);
    pd(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h100, 32'h0);
    run(5);
    check("p6_count", cap_d.size(), 32'd1);
    check("p6_read", qget(cap_d, 0), 32'hDEAD_BEEF);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
